// File: rtl/sum_uart_pkg.sv
// -----------------------------------------------------------------------------
// sum_uart_pkg
//
// Shared definitions for the sum-to-terminal path that sits between the 4-bit
// adder and uart_tx.
//
// Contents:
//   state_t         sequencing states of sum_ascii_sender
//   ASCII_ZERO      '0' character, OR-ed with a decimal digit to form ASCII
//   ASCII_CR        carriage return
//   ASCII_LF        line feed
//   MAX_DIGITS      largest number of decimal digits a sum can need
//   MAX_BYTES       digits plus the optional CR LF trailer
//   BYTE_IDX_WIDTH  width of an index that walks a full byte list
//   digit_to_ascii  converts a 0..9 digit to its ASCII character
// -----------------------------------------------------------------------------
package sum_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    LOAD,
    PULSE,
    WAIT_HI,
    WAIT_LO,
    NEXT
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam int MAX_DIGITS     = 2;
  localparam int MAX_BYTES      = MAX_DIGITS + 2;
  localparam int BYTE_IDX_WIDTH = $clog2(MAX_BYTES);

  // A digit never exceeds 9, so OR-ing into 0x30 can never carry into the
  // upper nibble; this is cheaper than an adder and gives the same result.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
    return ASCII_ZERO | {4'h0, digit};
  endfunction

endpackage

// File: rtl/bin_to_dec2.sv
// -----------------------------------------------------------------------------
// bin_to_dec2
//
// Serial binary-to-two-digit-decimal converter. A start pulse captures the
// value; from then on ten is subtracted once per cycle, counting the
// subtractions into the tens digit, until what remains is below ten and
// becomes the ones digit. The largest legal input (63) takes seven cycles
// from start to valid.
//
// Ports:
//   clk    in   1            system clock
//   reset  in   1            synchronous, active-high reset
//   start  in   1            capture value and begin converting
//   value  in   VALUE_WIDTH  unsigned binary input, at most 63
//   tens   out  3            tens digit, held until the next start
//   ones   out  4            ones digit, held until the next start
//   valid  out  1            one-cycle pulse when tens/ones are final
// -----------------------------------------------------------------------------
module bin_to_dec2
  import sum_uart_pkg::*;
#(
  parameter int VALUE_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [VALUE_WIDTH-1:0] value,
  output logic [2:0]             tens,
  output logic [3:0]             ones,
  output logic                   valid
);

  // Six bits covers every legal input width (up to 63), so the working
  // register is fixed at that size regardless of VALUE_WIDTH.
  localparam int REM_WIDTH = 6;
  localparam logic [REM_WIDTH-1:0] TEN = REM_WIDTH'(10);

  logic [REM_WIDTH-1:0] remainder;
  logic                 running;

  // Repeated-subtraction divider. A new start always wins over a conversion
  // still in flight, and valid only ever lasts a single cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      remainder <= '0;
      running   <= 1'b0;
      tens      <= '0;
      ones      <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        remainder <= REM_WIDTH'(value);
        tens      <= '0;
        running   <= 1'b1;
      end else if (running) begin
        if (remainder >= TEN) begin
          remainder <= remainder - TEN;
          tens      <= tens + 3'd1;
        end else begin
          ones    <= remainder[3:0];
          valid   <= 1'b1;
          running <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sum_ascii_sender.sv
// -----------------------------------------------------------------------------
// sum_ascii_sender
//
// Captures the adder's sum on request, converts it to decimal ASCII with the
// leading zero suppressed, and hands the characters to uart_tx one at a time
// over its en/busy handshake, optionally followed by CR LF so a terminal
// shows one result per line.
//
// Ports:
//   clk           in   1          system clock
//   reset         in   1          synchronous, active-high reset
//   send_req      in   1          request to send sum_in; ignored while busy
//   sum_in        in   SUM_WIDTH  unsigned sum from the adder
//   uartbusy      in   1          busy flag from uart_tx
//   uart_tx_en    out  1          one-cycle start pulse to uart_tx
//   uart_tx_data  out  8          byte for uart_tx; held until the next load
//   busy          out  1          high from an accepted request to completion
//   done          out  1          one-cycle pulse after the last byte finishes
//
// Parameters:
//   SUM_WIDTH    width of sum_in, 1..6
//   SEND_CRLF    1 appends CR LF after the digits, 0 sends digits only
//   ACK_TIMEOUT  cycles to wait for uartbusy to rise before re-pulsing
// -----------------------------------------------------------------------------
module sum_ascii_sender
  import sum_uart_pkg::*;
#(
  parameter int SUM_WIDTH   = 5,
  parameter bit SEND_CRLF   = 1'b1,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 send_req,
  input  logic [SUM_WIDTH-1:0] sum_in,
  input  logic                 uartbusy,
  output logic                 uart_tx_en,
  output logic [7:0]           uart_tx_data,
  output logic                 busy,
  output logic                 done
);

  localparam int TIMER_WIDTH = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST  = TIMER_WIDTH'(ACK_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_STEP  = TIMER_WIDTH'(1);

  // The byte index addresses a fixed list layout: tens, ones, CR, LF. A sum
  // below ten simply starts at the ones slot, and a digits-only build stops
  // there, so no separate length counter is needed.
  localparam logic [BYTE_IDX_WIDTH-1:0] IDX_TENS = BYTE_IDX_WIDTH'(0);
  localparam logic [BYTE_IDX_WIDTH-1:0] IDX_ONES = BYTE_IDX_WIDTH'(1);
  localparam logic [BYTE_IDX_WIDTH-1:0] IDX_CR   = BYTE_IDX_WIDTH'(2);
  localparam logic [BYTE_IDX_WIDTH-1:0] IDX_LF   = BYTE_IDX_WIDTH'(3);
  localparam logic [BYTE_IDX_WIDTH-1:0] IDX_LAST = SEND_CRLF ? IDX_LF : IDX_ONES;
  localparam logic [BYTE_IDX_WIDTH-1:0] IDX_STEP = BYTE_IDX_WIDTH'(1);

  state_t                    state;
  logic [BYTE_IDX_WIDTH-1:0] byte_idx;
  logic [TIMER_WIDTH-1:0]    timer;
  logic [7:0]                cur_byte;

  logic       conv_start;
  logic [2:0] conv_tens;
  logic [3:0] conv_ones;
  logic       conv_valid;

  // The converter latches sum_in on the same edge that accepts the request,
  // so later changes on sum_in cannot leak into the frame.
  assign conv_start = (state == IDLE) && send_req;

  bin_to_dec2 #(
    .VALUE_WIDTH (SUM_WIDTH)
  ) u_bin_to_dec2 (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .value (sum_in),
    .tens  (conv_tens),
    .ones  (conv_ones),
    .valid (conv_valid)
  );

  // Character for the slot the byte index currently points at. The converter
  // holds its digits for the whole frame, so this stays valid until IDLE.
  always_comb begin
    cur_byte = ASCII_LF;
    case (byte_idx)
      IDX_TENS: cur_byte = digit_to_ascii({1'b0, conv_tens});
      IDX_ONES: cur_byte = digit_to_ascii(conv_ones);
      IDX_CR:   cur_byte = ASCII_CR;
      default:  cur_byte = ASCII_LF;
    endcase
  end

  // Frame sequencer and uart_tx handshake. The start pulse is raised on the
  // edge that enters PULSE so that it is high for exactly the PULSE cycle.
  // If uart_tx never acknowledges, the same byte is re-pulsed after
  // ACK_TIMEOUT cycles in WAIT_HI. uart_tx_data is deliberately left alone
  // outside LOAD so the last character stays on the bus while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      byte_idx     <= '0;
      timer        <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      uart_tx_en <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (send_req) begin
            busy  <= 1'b1;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          if (conv_valid) begin
            byte_idx <= (conv_tens != 3'd0) ? IDX_TENS : IDX_ONES;
            state    <= LOAD;
          end
        end
        LOAD: begin
          uart_tx_data <= cur_byte;
          uart_tx_en   <= 1'b1;
          state        <= PULSE;
        end
        PULSE: begin
          timer <= '0;
          state <= uartbusy ? WAIT_LO : WAIT_HI;
        end
        WAIT_HI: begin
          if (uartbusy) begin
            state <= WAIT_LO;
          end else if (timer == TIMER_LAST) begin
            timer      <= '0;
            uart_tx_en <= 1'b1;
            state      <= PULSE;
          end else begin
            timer <= timer + TIMER_STEP;
          end
        end
        WAIT_LO: begin
          if (!uartbusy) begin
            state <= NEXT;
          end
        end
        NEXT: begin
          if (byte_idx != IDX_LAST) begin
            byte_idx <= byte_idx + IDX_STEP;
            state    <= LOAD;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_ascii_sender.sv
// -----------------------------------------------------------------------------
// tb_sum_ascii_sender
//
// Two instances share the clock and sum_in: dut_a appends CR LF and uses a
// short acknowledge timeout, dut_b sends digits only. Each has a small
// uart_tx stand-in that holds busy for a fixed number of cycles per accepted
// byte and records what it received. Expected byte streams are built from
// plain decimal arithmetic on the requested value.
// -----------------------------------------------------------------------------
module tb_sum_ascii_sender;

  localparam int SW      = 5;
  localparam int TMO     = 15;
  localparam int HOLD_A  = 20;
  localparam int HOLD_B  = 3;
  localparam int BUDGET  = 3000;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] sum_in;
  logic          send_req_a, send_req_b;
  logic          ubusy_a = 1'b0;
  logic          ubusy_b = 1'b0;
  logic          en_a, en_b;
  logic [7:0]    data_a, data_b;
  logic          busy_a, busy_b, done_a, done_b;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  logic [7:0] en_data_a[$];
  int         en_cycles_a[$];
  logic [7:0] exp_q[$];

  int en_count_a = 0, done_count_a = 0, hold_cnt_a = 0, dropped_a = 0;
  int en_count_b = 0, done_count_b = 0, hold_cnt_b = 0;
  int drop_target_a = 0;

  always #5 clk = ~clk;

  sum_ascii_sender #(
    .SUM_WIDTH   (SW),
    .SEND_CRLF   (1'b1),
    .ACK_TIMEOUT (TMO)
  ) dut_a (
    .clk          (clk),
    .reset        (reset),
    .send_req     (send_req_a),
    .sum_in       (sum_in),
    .uartbusy     (ubusy_a),
    .uart_tx_en   (en_a),
    .uart_tx_data (data_a),
    .busy         (busy_a),
    .done         (done_a)
  );

  sum_ascii_sender #(
    .SUM_WIDTH   (SW),
    .SEND_CRLF   (1'b0),
    .ACK_TIMEOUT (TMO)
  ) dut_b (
    .clk          (clk),
    .reset        (reset),
    .send_req     (send_req_b),
    .sum_in       (sum_in),
    .uartbusy     (ubusy_b),
    .uart_tx_en   (en_b),
    .uart_tx_data (data_b),
    .busy         (busy_b),
    .done         (done_b)
  );

  // Free-running cycle counter used to timestamp start pulses.
  always @(posedge clk) begin
    cycle <= cycle + 1;
  end

  // uart_tx stand-in for dut_a: can be told to ignore pulses, otherwise
  // accepts a byte and holds busy for HOLD_A cycles.
  always @(posedge clk) begin
    if (en_a) begin
      en_count_a <= en_count_a + 1;
      en_cycles_a.push_back(cycle);
      en_data_a.push_back(data_a);
    end
    if (done_a) done_count_a <= done_count_a + 1;
    if (hold_cnt_a != 0) begin
      if (hold_cnt_a == 1) ubusy_a <= 1'b0;
      hold_cnt_a <= hold_cnt_a - 1;
    end else if (en_a) begin
      if (dropped_a < drop_target_a) begin
        dropped_a <= dropped_a + 1;
      end else begin
        got_a.push_back(data_a);
        ubusy_a    <= 1'b1;
        hold_cnt_a <= HOLD_A;
      end
    end
  end

  // uart_tx stand-in for dut_b with a short busy time.
  always @(posedge clk) begin
    if (en_b) en_count_b <= en_count_b + 1;
    if (done_b) done_count_b <= done_count_b + 1;
    if (hold_cnt_b != 0) begin
      if (hold_cnt_b == 1) ubusy_b <= 1'b0;
      hold_cnt_b <= hold_cnt_b - 1;
    end else if (en_b) begin
      got_b.push_back(data_b);
      ubusy_b    <= 1'b1;
      hold_cnt_b <= HOLD_B;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Expected characters: decimal digits without a leading zero, then CR LF.
  task automatic buildExpected(input int value, input bit crlf);
    exp_q = {};
    if (value / 10 != 0) exp_q.push_back(8'(8'h30 + value / 10));
    exp_q.push_back(8'(8'h30 + value % 10));
    if (crlf) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  // One-cycle request, then sum_in is scrambled to prove it was captured.
  task automatic applyStimulus(input bit use_b, input logic [SW-1:0] value);
    @(negedge clk);
    sum_in = value;
    if (use_b) send_req_b = 1'b1; else send_req_a = 1'b1;
    @(negedge clk);
    send_req_a = 1'b0;
    send_req_b = 1'b0;
    sum_in = SW'($urandom);
  endtask

  task automatic runFrame(input string tag, input bit use_b, input logic [SW-1:0] value,
                          input int extra_en, input int inject_delay,
                          input logic [SW-1:0] inject_value);
    int base_bytes, base_en, base_done, waited, got_len;
    logic [7:0] got_byte;
    buildExpected(int'(value), !use_b);
    base_bytes = use_b ? got_b.size() : got_a.size();
    base_en    = use_b ? en_count_b : en_count_a;
    base_done  = use_b ? done_count_b : done_count_a;
    applyStimulus(use_b, value);
    checkOutput({tag, ".busy_rise"}, 32'(use_b ? busy_b : busy_a), 32'd1);
    waited = 0;
    while ((use_b ? done_b : done_a) !== 1'b1 && waited < BUDGET) begin
      if (inject_delay != 0 && waited == inject_delay) begin
        sum_in = inject_value;
        if (use_b) send_req_b = 1'b1; else send_req_a = 1'b1;
      end else begin
        send_req_a = 1'b0;
        send_req_b = 1'b0;
      end
      @(negedge clk);
      waited++;
    end
    send_req_a = 1'b0;
    send_req_b = 1'b0;
    checkOutput({tag, ".done_in_budget"}, 32'(waited < BUDGET), 32'd1);
    checkOutput({tag, ".busy_at_done"}, 32'(use_b ? busy_b : busy_a), 32'd0);
    @(negedge clk);
    checkOutput({tag, ".done_one_cycle"}, 32'(use_b ? done_b : done_a), 32'd0);
    got_len = (use_b ? got_b.size() : got_a.size()) - base_bytes;
    checkOutput({tag, ".byte_count"}, 32'(got_len), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_len) begin
        got_byte = use_b ? got_b[base_bytes + i] : got_a[base_bytes + i];
        checkOutput($sformatf("%s.byte%0d", tag, i), 32'(got_byte), 32'(exp_q[i]));
      end
    end
    checkOutput({tag, ".en_pulses"},
                32'((use_b ? en_count_b : en_count_a) - base_en),
                32'(exp_q.size() + extra_en));
    checkOutput({tag, ".done_pulses"},
                32'((use_b ? done_count_b : done_count_a) - base_done), 32'd1);
    checkOutput({tag, ".data_held"}, 32'(use_b ? data_b : data_a),
                32'(exp_q[exp_q.size() - 1]));
  endtask

  initial begin
    int base_en, base_bytes, waited;
    logic [SW-1:0] rnd;

    reset      = 1'b1;
    send_req_a = 1'b0;
    send_req_b = 1'b0;
    sum_in     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.en_a",   32'(en_a),   32'd0);
    checkOutput("reset.data_a", 32'(data_a), 32'h00);
    checkOutput("reset.busy_a", 32'(busy_a), 32'd0);
    checkOutput("reset.done_a", 32'(done_a), 32'd0);
    checkOutput("reset.en_b",   32'(en_b),   32'd0);
    checkOutput("reset.busy_b", 32'(busy_b), 32'd0);

    // Request coinciding with reset must be dropped.
    sum_in     = 5'd3;
    send_req_a = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    send_req_a = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset_wins.busy", 32'(busy_a), 32'd0);
    checkOutput("reset_wins.en_count", 32'(en_count_a), 32'd0);

    runFrame("seven",   1'b0, 5'd7,  0, 0, '0);
    runFrame("thirty",  1'b0, 5'd30, 0, 0, '0);
    runFrame("ten",     1'b0, 5'd10, 0, 0, '0);
    runFrame("b_zero",  1'b1, 5'd0,  0, 0, '0);
    runFrame("b_nine",  1'b1, 5'd9,  0, 0, '0);
    runFrame("b_max",   1'b1, 5'd31, 0, 0, '0);

    // A second request while busy must vanish without trace.
    runFrame("dropped_req", 1'b0, 5'd12, 0, 40, 5'd9);

    // First start pulse is ignored by uart_tx; the byte must be re-pulsed.
    drop_target_a = 1;
    base_en = en_count_a;
    runFrame("retry", 1'b0, 5'd12, 1, 0, '0);
    if (en_cycles_a.size() >= base_en + 2) begin
      checkOutput("retry.gap", 32'(en_cycles_a[base_en + 1] - en_cycles_a[base_en]),
                  32'(TMO + 1));
      checkOutput("retry.first_byte",  32'(en_data_a[base_en]),     32'h31);
      checkOutput("retry.second_byte", 32'(en_data_a[base_en + 1]), 32'h31);
    end else begin
      checkOutput("retry.pulse_log", 32'(en_cycles_a.size() - base_en), 32'd2);
    end

    // Abort mid-frame while the second byte is in flight.
    base_bytes = got_a.size();
    applyStimulus(1'b0, 5'd25);
    waited = 0;
    while (got_a.size() < base_bytes + 2 && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("abort.second_byte_started", 32'(waited < BUDGET), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort.en",    32'(en_a),   32'd0);
    checkOutput("abort.busy",  32'(busy_a), 32'd0);
    checkOutput("abort.done",  32'(done_a), 32'd0);
    checkOutput("abort.state", 32'(dut_a.state), 32'(sum_uart_pkg::IDLE));
    waited = 0;
    while (ubusy_a !== 1'b0 && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("abort.uart_idle", 32'(waited < BUDGET), 32'd1);
    @(negedge clk);
    runFrame("after_abort", 1'b0, 5'd4, 0, 0, '0);

    for (int i = 0; i < 5; i++) begin
      rnd = SW'($urandom_range(31, 0));
      runFrame($sformatf("rand_a%0d", i), 1'b0, rnd, 0, 0, '0);
    end
    for (int i = 0; i < 5; i++) begin
      rnd = SW'($urandom_range(31, 0));
      runFrame($sformatf("rand_b%0d", i), 1'b1, rnd, 0, 0, '0);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
